calendar_date_counter: RTL and testbench
========================================

# calendar_date_counter

Registered calendar date source that advances one day per `day_tick` and supports a checked parallel load. It drives `dayOfMonth`/`month` directly into the day-of-year calculator downstream and supplies `year`/`is_leap` for leap-aware consumers. All outputs are registered, so the downstream stage sees stable, always-legal dates.

## Interface
- `RESET_YEAR`, default 2000: year value loaded on reset. Must be in 0..4095.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `day_tick` input 1: single-cycle strobe that advances the date by one day.
- `load` input 1: single-cycle strobe that requests a load of `load_day`/`load_month`/`load_year`.
- `load_day` input 6: day to load, legal range 1..days-in-month.
- `load_month` input 4: month to load, legal range 1..12.
- `load_year` input 12: year to load, range 0..4095.
- `dayOfMonth` output 6: current day, 1..31.
- `month` output 4: current month, 1..12.
- `year` output 12: current year, 0..4095.
- `is_leap` output 1: 1 when `year` is a Gregorian leap year.
- `date_changed` output 1: one-cycle pulse after any date update.
- `load_err` output 1: one-cycle pulse when a load request is rejected.
- `year_wrap` output 1: one-cycle pulse when the year rolls over from 4095 to 0.

## Operation
- Reset state:
  - `dayOfMonth`=1, `month`=1, `year`=RESET_YEAR, `is_leap`=leap(RESET_YEAR).
  - `date_changed`=0, `load_err`=0, `year_wrap`=0.
- Leap rule: (y%4==0) && ((y%100!=0) || (y%400==0)). Year 0 is leap.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 if leap, else 28.
- Tick (`day_tick`=1, `load`=0):
  - If day < dim(month, year): day+1.
  - Otherwise day=1 and the month advances.
  - Month advance: month+1; past month 12 it becomes 1 and year+1.
  - Year 4095 wraps to 0 and asserts `year_wrap`.
- Load (`load`=1) is valid iff month is in 1..12 and day is in 1..dim(load_month, load_year).
  - Valid load: all three registers take the load values; `date_changed` pulses.
  - Invalid load: the state is unchanged; `load_err` pulses; `date_changed` stays 0.
- Simultaneous `load` and `day_tick`: the load wins and the tick is discarded, even if the load is invalid.
- `is_leap` is recomputed from the next-state year, so it is always consistent with `year` in the same cycle.
- Pulses are only ever 1 for exactly one cycle; consecutive ticks on back-to-back cycles give back-to-back pulses.
- An out-of-range state is unreachable: no reset or load path produces day 0, month 0, or month >12.

## Timing
- Latency: one cycle from an input strobe at edge N to updated outputs and pulses visible after edge N+1.
- Full tick throughput: `day_tick` may be high every cycle, advancing one day per cycle.
- No handshake: strobes are sampled on every edge and are not held.
- Reset mid-operation: outputs take their reset values asynchronously and immediately; a strobe pending in that cycle is lost.
- Release of `reset_n` must be synchronous to `clk` externally. The first edge after release may carry a valid tick.

## Structure
- Shared package `calendar_pkg` holds:
  - `typedef` `day_t` (6b), `month_t` (4b), `year_t` (12b).
  - Month constants `JAN`..`DEC`.
  - `MAX_YEAR`=4095.
  - Function `is_leap_year(year_t)`.
  - Function `days_in_month(month_t, logic leap)`.
- Sub-module `days_in_month_lut`: combinational, inputs month and leap, output 5-bit day count. It is instantiated twice, once for the current date (tick path) and once for the load values (validation path).
- Leap detection: the %100 and %400 checks are done on the 12-bit year by constant comparison or a small ROM. A divider is not allowed.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle -> outputs 01/01/2000 immediately with all pulses 0. Release, then 31 ticks -> 01/02/2000, with `date_changed` high on every one of the 31 cycles.
- February: load 28/02/2023 then tick -> 01/03/2023, `is_leap`=0. Load 28/02/2024 then tick -> 29/02/2024, then tick -> 01/03/2024.
- Century rule: load 1900 -> `is_leap`=0, and 28/02/1900 + tick -> 01/03/1900. Load 2000 -> `is_leap`=1.
- Invalid loads: 31/04/2023, 29/02/2023, 00/05/2023 and 10/13/2023 -> `load_err`=1 for one cycle each, with the date unchanged and `date_changed`=0.
- Simultaneous strobes:
  - `load` 15/06/2010 with `day_tick` in the same cycle -> 15/06/2010, not 16/06.
  - Invalid load with tick -> date unchanged.
- Wrap: load 31/12/4095 then tick -> 01/01/0000, `year_wrap`=1 for one cycle, `is_leap`=1.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared calendar types, month constants and leap/month-length helpers.
package calendar_pkg;

    typedef logic [5:0]  day_t;
    typedef logic [3:0]  month_t;
    typedef logic [11:0] year_t;

    localparam month_t JAN = 4'd1;
    localparam month_t FEB = 4'd2;
    localparam month_t MAR = 4'd3;
    localparam month_t APR = 4'd4;
    localparam month_t MAY = 4'd5;
    localparam month_t JUN = 4'd6;
    localparam month_t JUL = 4'd7;
    localparam month_t AUG = 4'd8;
    localparam month_t SEP = 4'd9;
    localparam month_t OCT = 4'd10;
    localparam month_t NOV = 4'd11;
    localparam month_t DEC = 4'd12;

    localparam year_t MAX_YEAR = 12'd4095;

    // Century checks compare against the 41 multiples of 100 that fit in
    // 12 bits; every fourth of them is also a multiple of 400.
    function automatic logic is_leap_year(input year_t y);
        logic mult100;
        logic mult400;
        mult100 = 1'b0;
        mult400 = 1'b0;
        for (int unsigned k = 0; k <= 40; k++) begin
            if (y == year_t'(k * 100)) begin
                mult100 = 1'b1;
                if ((k % 4) == 0) mult400 = 1'b1;
            end
        end
        return (y[1:0] == 2'b00) && (!mult100 || mult400);
    endfunction

    // Returns 0 for an illegal month so any day compared against it fails.
    function automatic logic [4:0] days_in_month(input month_t m, input logic leap);
        logic [4:0] d;
        case (m)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: d = 5'd31;
            APR, JUN, SEP, NOV:                d = 5'd30;
            FEB:                               d = leap ? 5'd29 : 5'd28;
            default:                           d = 5'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/days_in_month_lut.sv
// Combinational month-length lookup.
module days_in_month_lut
    import calendar_pkg::*;
(
    input  month_t     month,
    input  logic       leap,
    output logic [4:0] days
);

    // Table lookup of the number of days in the given month.
    always_comb begin
        days = days_in_month(month, leap);
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Registered calendar date: one-day advance per tick, validated parallel load.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter year_t RESET_YEAR = 12'd2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        day_tick,
    input  logic        load,
    input  logic [5:0]  load_day,
    input  logic [3:0]  load_month,
    input  logic [11:0] load_year,
    output logic [5:0]  dayOfMonth,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic        is_leap,
    output logic        date_changed,
    output logic        load_err,
    output logic        year_wrap
);

    logic [4:0] cur_dim;
    logic [4:0] load_dim;
    logic       load_leap;
    logic       load_ok;
    day_t       day_n;
    month_t     month_n;
    year_t      year_n;
    logic       changed_n;
    logic       err_n;
    logic       wrap_n;

    days_in_month_lut u_cur_lut (
        .month (month),
        .leap  (is_leap),
        .days  (cur_dim)
    );

    days_in_month_lut u_load_lut (
        .month (load_month),
        .leap  (load_leap),
        .days  (load_dim)
    );

    // Validate the requested load against its own month/year.
    always_comb begin
        load_leap = is_leap_year(load_year);
        load_ok   = (load_month >= JAN) && (load_month <= DEC) &&
                    (load_day != 6'd0) && (load_day <= {1'b0, load_dim});
    end

    // Next date: load has priority over tick; a rejected load discards the tick.
    always_comb begin
        day_n     = dayOfMonth;
        month_n   = month;
        year_n    = year;
        changed_n = 1'b0;
        err_n     = 1'b0;
        wrap_n    = 1'b0;
        if (load) begin
            if (load_ok) begin
                day_n     = load_day;
                month_n   = load_month;
                year_n    = load_year;
                changed_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else if (day_tick) begin
            changed_n = 1'b1;
            if (dayOfMonth < {1'b0, cur_dim}) begin
                day_n = dayOfMonth + 6'd1;
            end else begin
                day_n = 6'd1;
                if (month == DEC) begin
                    month_n = JAN;
                    year_n  = year + 12'd1;
                    wrap_n  = (year == MAX_YEAR);
                end else begin
                    month_n = month + 4'd1;
                end
            end
        end
    end

    // Date, leap flag (from next-state year) and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dayOfMonth   <= 6'd1;
            month        <= JAN;
            year         <= RESET_YEAR;
            is_leap      <= is_leap_year(RESET_YEAR);
            date_changed <= 1'b0;
            load_err     <= 1'b0;
            year_wrap    <= 1'b0;
        end else begin
            dayOfMonth   <= day_n;
            month        <= month_n;
            year         <= year_n;
            is_leap      <= is_leap_year(year_n);
            date_changed <= changed_n;
            load_err     <= err_n;
            year_wrap    <= wrap_n;
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed self-checking bench for calendar_date_counter.
module tb_calendar_date_counter;

    logic        clk;
    logic        reset_n;
    logic        day_tick;
    logic        load;
    logic [5:0]  load_day;
    logic [3:0]  load_month;
    logic [11:0] load_year;
    logic [5:0]  dayOfMonth;
    logic [3:0]  month;
    logic [11:0] year;
    logic        is_leap;
    logic        date_changed;
    logic        load_err;
    logic        year_wrap;

    int passed;
    int total;
    logic [25:0] g;
    logic [25:0] e;

    calendar_date_counter #(.RESET_YEAR(12'd2000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .day_tick     (day_tick),
        .load         (load),
        .load_day     (load_day),
        .load_month   (load_month),
        .load_year    (load_year),
        .dayOfMonth   (dayOfMonth),
        .month        (month),
        .year         (year),
        .is_leap      (is_leap),
        .date_changed (date_changed),
        .load_err     (load_err),
        .year_wrap    (year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] pack(input int d, input int m, input int y,
                                         input logic l, input logic c,
                                         input logic er, input logic w);
        return {6'(d), 4'(m), 12'(y), l, c, er, w};
    endfunction

    function automatic logic [25:0] got();
        return {dayOfMonth, month, year, is_leap, date_changed, load_err, year_wrap};
    endfunction

    function automatic string fmt(input logic [25:0] v);
        return $sformatf("%0d/%0d/%0d leap=%b chg=%b err=%b wrap=%b",
                         v[25:20], v[19:16], v[15:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic step(input logic tk, input logic ld, input int d, input int m, input int y);
        day_tick   = tk;
        load       = ld;
        load_day   = 6'(d);
        load_month = 4'(m);
        load_year  = 12'(y);
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        load     = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        e = pack(1, 1, 2000, 1, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL reset_state: got %s expected %s", fmt(g), fmt(e)); else passed++;
        @(negedge clk) reset_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step(1, 0, 0, 0, 0);
            e = (i < 31) ? pack(i + 1, 1, 2000, 1, 1, 0, 0) : pack(1, 2, 2000, 1, 1, 0, 0);
            g = got(); total++;
            if (g !== e) $display("FAIL jan_tick_%0d: got %s expected %s", i, fmt(g), fmt(e)); else passed++;
        end
        step(0, 0, 0, 0, 0);
        e = pack(1, 2, 2000, 1, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL idle_after_ticks: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_midcycle_reset;
        step(0, 1, 15, 6, 2010);
        day_tick = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        e = pack(1, 1, 2000, 1, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL async_reset: got %s expected %s", fmt(g), fmt(e)); else passed++;
        @(posedge clk);
        #1 day_tick = 1'b0;
        e = pack(1, 1, 2000, 1, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL reset_held: got %s expected %s", fmt(g), fmt(e)); else passed++;
        @(negedge clk) reset_n = 1'b1;
        step(1, 0, 0, 0, 0);
        e = pack(2, 1, 2000, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL first_tick_after_release: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_february;
        step(0, 1, 28, 2, 2023);
        e = pack(28, 2, 2023, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL feb2023_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 0, 0, 0, 0);
        e = pack(1, 3, 2023, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL feb2023_tick: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 28, 2, 2024);
        e = pack(28, 2, 2024, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL feb2024_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 0, 0, 0, 0);
        e = pack(29, 2, 2024, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL feb2024_tick29: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 0, 0, 0, 0);
        e = pack(1, 3, 2024, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL feb2024_tick_mar: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 30, 4, 2024);
        step(1, 0, 0, 0, 0);
        e = pack(1, 5, 2024, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL apr30_tick: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_century;
        step(0, 1, 28, 2, 1900);
        e = pack(28, 2, 1900, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL y1900_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 0, 0, 0, 0);
        e = pack(1, 3, 1900, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL y1900_tick: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 1, 1, 2000);
        e = pack(1, 1, 2000, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL y2000_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 29, 2, 4000);
        e = pack(29, 2, 4000, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL y4000_feb29: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_invalid_loads;
        step(0, 1, 10, 5, 2023);
        e = pack(10, 5, 2023, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_baseline: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 31, 4, 2023);
        e = pack(10, 5, 2023, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_apr31: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 29, 2, 2023);
        e = pack(10, 5, 2023, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_feb29_2023: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 0, 5, 2023);
        e = pack(10, 5, 2023, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_day0: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 10, 13, 2023);
        e = pack(10, 5, 2023, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_month13: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 29, 2, 2100);
        e = pack(10, 5, 2023, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_feb29_2100: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 0, 0, 0, 0);
        e = pack(10, 5, 2023, 0, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL inv_err_clears: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_simultaneous;
        step(1, 1, 15, 6, 2010);
        e = pack(15, 6, 2010, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL sim_valid_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 1, 31, 4, 2010);
        e = pack(15, 6, 2010, 0, 0, 1, 0); g = got(); total++;
        if (g !== e) $display("FAIL sim_invalid_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    task automatic test_wrap;
        step(0, 1, 31, 12, 4095);
        e = pack(31, 12, 4095, 0, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL wrap_load: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(1, 0, 0, 0, 0);
        e = pack(1, 1, 0, 1, 1, 0, 1); g = got(); total++;
        if (g !== e) $display("FAIL wrap_tick: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 0, 0, 0, 0);
        e = pack(1, 1, 0, 1, 0, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL wrap_pulse_clears: got %s expected %s", fmt(g), fmt(e)); else passed++;
        step(0, 1, 31, 12, 2023);
        step(1, 0, 0, 0, 0);
        e = pack(1, 1, 2024, 1, 1, 0, 0); g = got(); total++;
        if (g !== e) $display("FAIL new_year_no_wrap: got %s expected %s", fmt(g), fmt(e)); else passed++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        reset_n    = 1'b1;
        day_tick   = 1'b0;
        load       = 1'b0;
        load_day   = '0;
        load_month = '0;
        load_year  = '0;
        test_reset;
        test_midcycle_reset;
        test_february;
        test_century;
        test_invalid_loads;
        test_simultaneous;
        test_wrap;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
